// File: rtl/branch_predictor_pkg.sv
// Shared types for the BTB branch predictor: counter encodings, entry layout, default sizes.
// Pure declarations; no timing or flow control of its own.
package bp_pkg;
  localparam int DEF_IDX_BITS = 6;
  localparam int DEF_TAG_BITS = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Tag is kept 32 bits wide so any TAG_BITS fits; unused upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [31:0] target;
    ctr_t        ctr;
  } btb_entry_t;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating counter step: up increments, otherwise decrements, clamped at ST/SNT.
// Combinational, zero latency; no flow control.
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] nxt
);
  always_comb begin
    nxt = ctr;
    if (up && ctr != ST) begin
      nxt = ctr + 2'd1;
    end else if (!up && ctr != SNT) begin
      nxt = ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB predictor: combinational fetch lookup, combinational execute redirect/flush,
// table and perf-counter updates on the resolving edge; never stalls the pipeline.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = DEF_IDX_BITS,
  parameter int TAG_BITS = DEF_TAG_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic        JumpE,
  input  logic        TakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [31:0] PCTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] PCRedirectE,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount
);
  localparam int          ENTRIES  = 1 << IDX_BITS;
  localparam logic [31:0] TAG_MASK = 32'((64'd1 << TAG_BITS) - 64'd1);

  btb_entry_t btb [ENTRIES];

  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [31:0]         tag_f, tag_e;
  btb_entry_t          ent_f;
  logic                hit_f, hit_e;
  logic                resolve, actual_taken;
  logic [1:0]          ctr_nxt;

  assign idx_f = PCF[IDX_BITS+1:2];
  assign idx_e = PCE[IDX_BITS+1:2];
  assign tag_f = (PCF >> (IDX_BITS + 2)) & TAG_MASK;
  assign tag_e = (PCE >> (IDX_BITS + 2)) & TAG_MASK;

  assign ent_f       = btb[idx_f];
  assign hit_f       = ent_f.valid && (ent_f.tag == tag_f);
  assign PredTakenF  = hit_f && ent_f.ctr[1];
  assign PredTargetF = PredTakenF ? ent_f.target : PCF + 32'd4;

  assign resolve      = BranchE || JumpE;
  assign actual_taken = JumpE || (BranchE && TakenE);
  assign hit_e        = btb[idx_e].valid && (btb[idx_e].tag == tag_e);

  // A taken prediction to the wrong target is as bad as a wrong direction.
  assign MispredictE = !reset && resolve &&
                       ((actual_taken != PredTakenE) ||
                        (actual_taken && (PredTargetE != PCTargetE)));
  assign PCRedirectE = actual_taken ? PCTargetE : PCPlus4E;
  assign FlushD      = MispredictE;
  assign FlushE      = MispredictE;

  sat_counter2 u_ctr (
    .ctr (btb[idx_e].ctr),
    .up  (actual_taken),
    .nxt (ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
      end
      BranchCount     <= '0;
      MispredictCount <= '0;
    end else begin
      if (resolve) begin
        if (hit_e) begin
          btb[idx_e].ctr <= ctr_t'(ctr_nxt);
          if (actual_taken) btb[idx_e].target <= PCTargetE;
        end else if (actual_taken) begin
          btb[idx_e] <= '{valid: 1'b1, tag: tag_e, target: PCTargetE,
                          ctr: (JumpE ? ST : WT)};
        end
        if (BranchCount != 32'hFFFF_FFFF) BranchCount <= BranchCount + 32'd1;
      end
      if (MispredictE && MispredictCount != 32'hFFFF_FFFF) begin
        MispredictCount <= MispredictCount + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;
  localparam int IDX  = 6;
  localparam int TAGB = 8;
  localparam int NENT = 1 << IDX;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCF, PredTargetF, PCE, PCPlus4E, PCTargetE, PredTargetE, PCRedirectE;
  logic        PredTakenF, BranchE, JumpE, TakenE, PredTakenE, MispredictE, FlushD, FlushE;
  logic [31:0] BranchCount, MispredictCount;

  int checks = 0;
  int failures = 0;

  // Reference model: per-entry fields as plain integers.
  bit          m_valid [NENT];
  int unsigned m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];
  longint      m_bc, m_mc;

  branch_predictor #(.IDX_BITS(IDX), .TAG_BITS(TAGB)) dut (
    .clk(clk), .reset(reset), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BranchE(BranchE), .JumpE(JumpE), .TakenE(TakenE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .PCTargetE(PCTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
    .MispredictE(MispredictE), .PCRedirectE(PCRedirectE), .FlushD(FlushD), .FlushE(FlushE),
    .BranchCount(BranchCount), .MispredictCount(MispredictCount)
  );

  always #5 clk = ~clk;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic int unsigned tag_of(logic [31:0] pc);
    return int'((pc / (4 * NENT)) % (1 << TAGB));
  endfunction

  function automatic bit m_pred_taken(logic [31:0] pc);
    int i = idx_of(pc);
    return m_valid[i] && m_tag[i] == tag_of(pc) && m_ctr[i] >= 2;
  endfunction

  function automatic logic [31:0] m_pred_target(logic [31:0] pc);
    return m_pred_taken(pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = '0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle: drive, check combinational outputs against the model, clock, advance the model.
  task automatic step(bit rst, logic [31:0] pcf, bit br, bit jp, bit tk, logic [31:0] pce,
                      bit pte, logic [31:0] ptgt, logic [31:0] tgt);
    bit at, res, mp, hit;
    int i;
    reset = rst; PCF = pcf; BranchE = br; JumpE = jp; TakenE = tk; PCE = pce;
    PCPlus4E = pce + 32'd4; PCTargetE = tgt; PredTakenE = pte; PredTargetE = ptgt;
    res = br || jp;
    at  = jp || (br && tk);
    mp  = !rst && res && ((at != pte) || (at && ptgt != tgt));
    #1;
    check("PredTakenF", 32'(PredTakenF), 32'(m_pred_taken(pcf)));
    check("PredTargetF", PredTargetF, m_pred_target(pcf));
    check("MispredictE", 32'(MispredictE), 32'(mp));
    check("FlushD", 32'(FlushD), 32'(mp));
    check("FlushE", 32'(FlushE), 32'(mp));
    if (res) check("PCRedirectE", PCRedirectE, at ? tgt : pce + 32'd4);
    check("BranchCount", BranchCount, 32'(m_bc));
    check("MispredictCount", MispredictCount, 32'(m_mc));
    @(posedge clk);
    if (rst) begin
      m_clear();
    end else if (res) begin
      i = idx_of(pce);
      hit = m_valid[i] && m_tag[i] == tag_of(pce);
      if (hit) begin
        if (at) begin
          m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_tgt[i] = tgt;
        end else begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
      end else if (at) begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(pce); m_tgt[i] = tgt; m_ctr[i] = jp ? 3 : 2;
      end
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
    end
    #1;
  endtask

  task automatic idle(logic [31:0] pcf);
    step(0, pcf, 0, 0, 0, 32'h0, 0, 32'h4, 32'h0);
  endtask

  task automatic rand_cycles(int n);
    logic [31:0] pcf, pce, tgt, ptgt;
    bit br, jp, pte;
    for (int k = 0; k < n; k++) begin
      pcf  = 32'($urandom_range(0, 511)) * 4;
      pce  = 32'($urandom_range(0, 511)) * 4;
      tgt  = 32'($urandom_range(0, 15)) * 64;
      jp   = ($urandom_range(0, 5) == 0);
      br   = !jp && ($urandom_range(0, 3) != 0);
      pte  = m_pred_taken(pce);
      ptgt = m_pred_target(pce);
      if ($urandom_range(0, 9) == 0) pte = !pte;
      if ($urandom_range(0, 9) == 0) ptgt = 32'($urandom_range(0, 15)) * 64;
      step(0, pcf, br, jp, 1'($urandom), pce, pte, ptgt, tgt);
    end
  endtask

  initial begin
    reset = 1'b1; PCF = '0; BranchE = 0; JumpE = 0; TakenE = 0; PCE = '0;
    PCPlus4E = 32'h4; PCTargetE = '0; PredTakenE = 0; PredTargetE = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle(32'h100);
    check("rst_PredTargetF_const", PredTargetF, 32'h104);

    // Branch at 0x100 taken to 0x80, predicted not taken
    step(0, 32'h100, 1, 0, 1, 32'h100, 0, 32'h104, 32'h80);
    idle(32'h100);
    check("alloc_PredTakenF_const", 32'(PredTakenF), 32'd1);
    check("alloc_PredTargetF_const", PredTargetF, 32'h80);

    // Not taken twice: 10 -> 01 -> 00
    step(0, 32'h100, 1, 0, 0, 32'h100, 1, 32'h80, 32'h80);
    step(0, 32'h100, 1, 0, 0, 32'h100, 0, 32'h104, 32'h80);
    idle(32'h100);

    // jal allocate, correct prediction, jalr target change
    step(0, 32'h200, 0, 1, 0, 32'h200, 0, 32'h204, 32'h400);
    step(0, 32'h200, 0, 1, 0, 32'h200, 1, 32'h400, 32'h400);
    step(0, 32'h200, 0, 1, 0, 32'h200, 1, 32'h400, 32'h500);
    idle(32'h200);
    check("jalr_PredTargetF_const", PredTargetF, 32'h500);

    // Aliasing: 0x100 shares the index with 0x200 and replaces it
    step(0, 32'h200, 1, 0, 1, 32'h100, 0, 32'h104, 32'h80);
    idle(32'h200);
    // Same-cycle lookup and not-taken update of 0x100: fetch sees the old taken entry
    step(0, 32'h100, 1, 0, 0, 32'h100, 1, 32'h80, 32'h80);
    idle(32'h100);

    // Counters: 10 resolutions, 3 mispredicts after a fresh reset
    step(1, 32'h0, 1, 0, 1, 32'h300, 0, 32'h304, 32'h380);
    step(0, 32'h0, 1, 0, 1, 32'h300, 0, 32'h304, 32'h380);
    for (int k = 0; k < 7; k++) step(0, 32'h300, 1, 0, 1, 32'h300, 1, 32'h380, 32'h380);
    step(0, 32'h0, 1, 0, 0, 32'h300, 1, 32'h380, 32'h380);
    step(0, 32'h0, 0, 1, 0, 32'h340, 0, 32'h344, 32'h10);
    idle(32'h300);
    check("cnt_branch_const", BranchCount, 32'd10);
    check("cnt_mispred_const", MispredictCount, 32'd3);

    // Random traffic, mid-stream reset, more traffic
    rand_cycles(300);
    step(1, 32'h340, 0, 1, 0, 32'h340, 0, 32'h0, 32'h10);
    check("rst_cnt_branch_const", BranchCount, 32'd0);
    check("rst_cnt_mispred_const", MispredictCount, 32'd0);
    for (int k = 0; k < NENT; k++) idle(32'(k) * 4 + 32'h300);
    rand_cycles(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
